logic_capture_mem_arb: RTL and testbench
========================================

Name: logic_capture_mem_arb

Overview:
- Two-requester arbiter that shares the single capture-memory request port (valid/write/addr/id/len/burst/wdata/wstrb with accept) between requester 0 (capture writer) and requester 1 (host readback / DMA).
- Keeps each write burst atomic: once the first beat of a burst is accepted, the grant is held until the last beat is accepted.
- Tags the request ID with the requester index and uses that tag to steer B and R responses back to the correct requester.
- Sits directly upstream of the AXI bridge's request port.

Parameters:
- PRIO_RR, 1, 1 = round-robin priority; 0 = fixed priority, requester 0 always wins.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous, active-low reset
- inN_valid_i / inN_write_i  in  1 / 1  request from requester N (N = 0, 1)
- inN_addr_i  in  32  request address
- inN_id_i  in  3  request ID
- inN_len_i  in  8  burst length, beats - 1
- inN_burst_i  in  2  burst type
- inN_wdata_i / inN_wstrb_i  in  32 / 4  write data and strobes
- inN_accept_o  out  1  request/beat accepted
- inN_bvalid_o / inN_bresp_o / inN_bid_o  out  1 / 2 / 3  write response
- inN_bready_i  in  1  write response ready
- inN_rvalid_o / inN_rdata_o / inN_rresp_o / inN_rid_o / inN_rlast_o  out  1 / 32 / 2 / 3 / 1  read response
- inN_rready_i  in  1  read response ready
- out_valid_o / out_write_o / out_addr_o / out_len_o / out_burst_o / out_wdata_o / out_wstrb_o  out  1/1/32/8/2/32/4  muxed request
- out_id_o  out  4  {grant index, 3-bit ID}
- out_accept_i  in  1  downstream accept
- out_bvalid_i / out_bresp_i / out_bid_i  in  1/2/4  write response
- out_bready_o  out  1  write response ready
- out_rvalid_i / out_rdata_i / out_rresp_i / out_rid_i / out_rlast_i  in  1/32/2/4/1  read response
- out_rready_o  out  1  read response ready

Behaviour:
- State: state_q {IDLE, LOCK}; owner_q (1b); beat_cnt_q (8b); prio_q (1b, favoured requester); hold_q (1b).
- Reset values: IDLE, owner 0, cnt 0, prio 0, hold 0.
- All outputs are combinational from state and inputs. With no requests: out_valid_o = 0, accepts = 0.
- Grant, IDLE with hold_q = 0:
  - only one requester valid → that requester;
  - both valid → prio_q (PRIO_RR = 1) or requester 0 (PRIO_RR = 0).
- Grant, IDLE with hold_q = 1: owner_q.
- Grant, LOCK: owner_q. The other requester is stalled (accept 0).
- Request mux: out_* = granted requester's fields; out_valid_o = granted valid; out_id_o = {grant, inG_id_i}.
- inG_accept_o = out_accept_i & granted; the non-granted accept is always 0. Zero-cycle latency; no registering of the payload.
- Hold: out_valid_o high && !out_accept_i in IDLE → hold_q <= 1, owner_q <= grant. This freezes the grant until accept, so the presented payload cannot change owner mid-handshake.
- On any accept: hold_q <= 0.
- Accept of a write with len > 0 in IDLE → LOCK, owner_q <= grant, beat_cnt_q <= len.
- Accept in LOCK → beat_cnt_q - 1. The accept with beat_cnt_q == 1 is the last beat: → IDLE.
- Read accept, or single-beat write accept (len == 0), keeps state IDLE.
- prio_q <= ~grant at completion of each transaction: read accept, len-0 write accept, or last LOCK beat. In fixed mode prio_q is unused.
- A requester dropping valid mid-burst in LOCK: grant stays held, out_valid_o = 0, and the other requester keeps waiting. No timeout.
- Response steering: inN_bvalid_o = out_bvalid_i & (out_bid_i[3] == N); bid/bresp broadcast with bid[2:0]; out_bready_o = inSEL_bready_i, SEL = out_bid_i[3]. R channel is identical, using out_rid_i[3].
- Responses are independent of request arbitration and may flow during LOCK.
- Reset mid-burst: immediate return to IDLE. Downstream is reset on the same reset.

Decomposition:
- Shared package: state encoding (ARB_IDLE, ARB_LOCK), field widths (ADDR_W 32, DATA_W 32, LEN_W 8, REQ_ID_W 3, OUT_ID_W 4).
- Sub-module logic_capture_mem_arb_resp_demux: stateless B/R steering by ID MSB, instantiated once per channel.

Test Plan:
- Single read from requester 1 (addr 0x100, id 2) with out_accept_i high → out_id_o = 4'hA; one-cycle accept to requester 1. R response rid 4'hA steered to in1 with rid 3'd2, in0_rvalid_o = 0.
- Both valid, requester 0 write len 3, requester 1 read → 4 write beats consecutive. in1_accept_o stays 0 until the 4th beat; the read is granted the next cycle.
- Burst lock with gaps: requester 0 drops valid after beat 2 of len 3 for 5 cycles while requester 1 is valid → no grant change; out_valid_o = 0 during the gap; burst resumes and completes.
- Round-robin: both issuing continuous single-beat reads → grants alternate 0,1,0,1. With PRIO_RR = 0 → requester 0 always wins.
- Hold: out_accept_i low for 3 cycles while requester 0 presents; requester 1 asserts in cycle 2 → payload and grant unchanged until accept.
- rst_ni asserted asynchronously in LOCK at beat 1 of len 7 → immediately IDLE, out_valid_o reflects new arbitration, beat_cnt_q = 0.

Source files
------------

// File: rtl/logic_capture_mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// logic_capture_mem_arb_pkg : shared widths and FSM encoding for the arbiter
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package logic_capture_mem_arb_pkg;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int STRB_W   = DATA_W / 8;
  localparam int LEN_W    = 8;
  localparam int REQ_ID_W = 3;
  localparam int OUT_ID_W = 4;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;
endpackage

`default_nettype wire

// File: rtl/logic_capture_mem_arb_resp_demux.sv
// ---------------------------------------------------------------------------
// logic_capture_mem_arb_resp_demux : stateless response steering by ID MSB
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module logic_capture_mem_arb_resp_demux
  import logic_capture_mem_arb_pkg::*;
#(
  parameter int PAYLOAD_W = 1
) (
  input  logic                 valid_i,
  input  logic                 sel_i,
  input  logic [PAYLOAD_W-1:0] payload_i,
  output logic                 ready_o,
  output logic                 valid0_o,
  output logic                 valid1_o,
  output logic [PAYLOAD_W-1:0] payload_o,
  input  logic                 ready0_i,
  input  logic                 ready1_i
);
  assign valid0_o  = valid_i & ~sel_i;
  assign valid1_o  = valid_i & sel_i;
  assign payload_o = payload_i;
  assign ready_o   = sel_i ? ready1_i : ready0_i;
endmodule

`default_nettype wire

// File: rtl/logic_capture_mem_arb.sv
// ---------------------------------------------------------------------------
// logic_capture_mem_arb : two-requester capture-memory arbiter, atomic bursts
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module logic_capture_mem_arb
  import logic_capture_mem_arb_pkg::*;
#(
  parameter bit PRIO_RR = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                in0_valid_i,
  input  logic                in0_write_i,
  input  logic [ADDR_W-1:0]   in0_addr_i,
  input  logic [REQ_ID_W-1:0] in0_id_i,
  input  logic [LEN_W-1:0]    in0_len_i,
  input  logic [1:0]          in0_burst_i,
  input  logic [DATA_W-1:0]   in0_wdata_i,
  input  logic [STRB_W-1:0]   in0_wstrb_i,
  output logic                in0_accept_o,
  output logic                in0_bvalid_o,
  output logic [1:0]          in0_bresp_o,
  output logic [REQ_ID_W-1:0] in0_bid_o,
  input  logic                in0_bready_i,
  output logic                in0_rvalid_o,
  output logic [DATA_W-1:0]   in0_rdata_o,
  output logic [1:0]          in0_rresp_o,
  output logic [REQ_ID_W-1:0] in0_rid_o,
  output logic                in0_rlast_o,
  input  logic                in0_rready_i,
  input  logic                in1_valid_i,
  input  logic                in1_write_i,
  input  logic [ADDR_W-1:0]   in1_addr_i,
  input  logic [REQ_ID_W-1:0] in1_id_i,
  input  logic [LEN_W-1:0]    in1_len_i,
  input  logic [1:0]          in1_burst_i,
  input  logic [DATA_W-1:0]   in1_wdata_i,
  input  logic [STRB_W-1:0]   in1_wstrb_i,
  output logic                in1_accept_o,
  output logic                in1_bvalid_o,
  output logic [1:0]          in1_bresp_o,
  output logic [REQ_ID_W-1:0] in1_bid_o,
  input  logic                in1_bready_i,
  output logic                in1_rvalid_o,
  output logic [DATA_W-1:0]   in1_rdata_o,
  output logic [1:0]          in1_rresp_o,
  output logic [REQ_ID_W-1:0] in1_rid_o,
  output logic                in1_rlast_o,
  input  logic                in1_rready_i,
  output logic                out_valid_o,
  output logic                out_write_o,
  output logic [ADDR_W-1:0]   out_addr_o,
  output logic [OUT_ID_W-1:0] out_id_o,
  output logic [LEN_W-1:0]    out_len_o,
  output logic [1:0]          out_burst_o,
  output logic [DATA_W-1:0]   out_wdata_o,
  output logic [STRB_W-1:0]   out_wstrb_o,
  input  logic                out_accept_i,
  input  logic                out_bvalid_i,
  input  logic [1:0]          out_bresp_i,
  input  logic [OUT_ID_W-1:0] out_bid_i,
  output logic                out_bready_o,
  input  logic                out_rvalid_i,
  input  logic [DATA_W-1:0]   out_rdata_i,
  input  logic [1:0]          out_rresp_i,
  input  logic [OUT_ID_W-1:0] out_rid_i,
  input  logic                out_rlast_i,
  output logic                out_rready_o
);
  localparam int B_W = 2 + REQ_ID_W;
  localparam int R_W = DATA_W + 2 + REQ_ID_W + 1;

  arb_state_e       r_state, w_state_nxt;
  logic             r_owner, w_owner_nxt;
  logic [LEN_W-1:0] r_beat_cnt, w_beat_cnt_nxt;
  logic             r_prio, w_prio_nxt;
  logic             r_hold, w_hold_nxt;
  logic             w_grant;
  logic             w_fire;
  logic [REQ_ID_W-1:0] w_id;

  // Owner is frozen while a burst is locked or a presented beat awaits accept.
  always_comb begin
    w_grant = 1'b0;
    if (r_state == ARB_LOCK || r_hold) begin
      w_grant = r_owner;
    end else if (in0_valid_i && in1_valid_i) begin
      w_grant = PRIO_RR ? r_prio : 1'b0;
    end else if (in1_valid_i) begin
      w_grant = 1'b1;
    end
  end

  always_comb begin
    out_valid_o = w_grant ? in1_valid_i : in0_valid_i;
    out_write_o = w_grant ? in1_write_i : in0_write_i;
    out_addr_o  = w_grant ? in1_addr_i  : in0_addr_i;
    out_len_o   = w_grant ? in1_len_i   : in0_len_i;
    out_burst_o = w_grant ? in1_burst_i : in0_burst_i;
    out_wdata_o = w_grant ? in1_wdata_i : in0_wdata_i;
    out_wstrb_o = w_grant ? in1_wstrb_i : in0_wstrb_i;
    w_id        = w_grant ? in1_id_i    : in0_id_i;
  end

  assign out_id_o     = {w_grant, w_id};
  assign w_fire       = out_valid_o & out_accept_i;
  assign in0_accept_o = w_fire & ~w_grant;
  assign in1_accept_o = w_fire & w_grant;

  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_beat_cnt_nxt = r_beat_cnt;
    w_prio_nxt     = r_prio;
    w_hold_nxt     = r_hold;
    if (w_fire) begin
      w_hold_nxt = 1'b0;
    end else if (out_valid_o && r_state == ARB_IDLE) begin
      w_hold_nxt  = 1'b1;
      w_owner_nxt = w_grant;
    end
    case (r_state)
      ARB_IDLE: begin
        if (w_fire) begin
          if (out_write_o && out_len_o != '0) begin
            w_state_nxt    = ARB_LOCK;
            w_owner_nxt    = w_grant;
            w_beat_cnt_nxt = out_len_o;
          end else begin
            w_prio_nxt = ~w_grant;
          end
        end
      end
      ARB_LOCK: begin
        if (w_fire) begin
          w_beat_cnt_nxt = r_beat_cnt - LEN_W'(1);
          if (r_beat_cnt == LEN_W'(1)) begin
            w_state_nxt = ARB_IDLE;
            w_prio_nxt  = ~w_grant;
          end
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= ARB_IDLE;
      r_owner    <= 1'b0;
      r_beat_cnt <= '0;
      r_prio     <= 1'b0;
      r_hold     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      r_prio     <= w_prio_nxt;
      r_hold     <= w_hold_nxt;
    end
  end

  logic_capture_mem_arb_resp_demux #(.PAYLOAD_W(B_W)) u_b_demux (
    .valid_i   (out_bvalid_i),
    .sel_i     (out_bid_i[OUT_ID_W-1]),
    .payload_i ({out_bresp_i, out_bid_i[REQ_ID_W-1:0]}),
    .ready_o   (out_bready_o),
    .valid0_o  (in0_bvalid_o),
    .valid1_o  (in1_bvalid_o),
    .payload_o ({in0_bresp_o, in0_bid_o}),
    .ready0_i  (in0_bready_i),
    .ready1_i  (in1_bready_i)
  );

  assign in1_bresp_o = in0_bresp_o;
  assign in1_bid_o   = in0_bid_o;

  logic_capture_mem_arb_resp_demux #(.PAYLOAD_W(R_W)) u_r_demux (
    .valid_i   (out_rvalid_i),
    .sel_i     (out_rid_i[OUT_ID_W-1]),
    .payload_i ({out_rdata_i, out_rresp_i, out_rid_i[REQ_ID_W-1:0], out_rlast_i}),
    .ready_o   (out_rready_o),
    .valid0_o  (in0_rvalid_o),
    .valid1_o  (in1_rvalid_o),
    .payload_o ({in0_rdata_o, in0_rresp_o, in0_rid_o, in0_rlast_o}),
    .ready0_i  (in0_rready_i),
    .ready1_i  (in1_rready_i)
  );

  assign in1_rdata_o = in0_rdata_o;
  assign in1_rresp_o = in0_rresp_o;
  assign in1_rid_o   = in0_rid_o;
  assign in1_rlast_o = in0_rlast_o;
endmodule

`default_nettype wire

// File: tb/tb_logic_capture_mem_arb.sv
// ---------------------------------------------------------------------------
// tb_logic_capture_mem_arb : self-checking bench for logic_capture_mem_arb
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_logic_capture_mem_arb;
  logic clk_i = 1'b0;
  logic rst_ni, f_rst_n;
  always #5 clk_i = ~clk_i;

  logic in0_valid_i, in0_write_i, in0_bready_i, in0_rready_i;
  logic [31:0] in0_addr_i, in0_wdata_i;
  logic [2:0] in0_id_i;
  logic [7:0] in0_len_i;
  logic [1:0] in0_burst_i;
  logic [3:0] in0_wstrb_i;
  logic in1_valid_i, in1_write_i, in1_bready_i, in1_rready_i;
  logic [31:0] in1_addr_i, in1_wdata_i;
  logic [2:0] in1_id_i;
  logic [7:0] in1_len_i;
  logic [1:0] in1_burst_i;
  logic [3:0] in1_wstrb_i;
  logic out_accept_i, out_bvalid_i, out_rvalid_i, out_rlast_i;
  logic [1:0] out_bresp_i, out_rresp_i;
  logic [3:0] out_bid_i, out_rid_i;
  logic [31:0] out_rdata_i;

  logic in0_accept_o, in0_bvalid_o, in0_rvalid_o, in0_rlast_o;
  logic in1_accept_o, in1_bvalid_o, in1_rvalid_o, in1_rlast_o;
  logic [1:0] in0_bresp_o, in0_rresp_o, in1_bresp_o, in1_rresp_o;
  logic [2:0] in0_bid_o, in0_rid_o, in1_bid_o, in1_rid_o;
  logic [31:0] in0_rdata_o, in1_rdata_o, out_addr_o, out_wdata_o;
  logic out_valid_o, out_write_o, out_bready_o, out_rready_o;
  logic [3:0] out_id_o, out_wstrb_o;
  logic [7:0] out_len_o;
  logic [1:0] out_burst_o;

  logic f_in0_accept_o, f_in0_bvalid_o, f_in0_rvalid_o, f_in0_rlast_o;
  logic f_in1_accept_o, f_in1_bvalid_o, f_in1_rvalid_o, f_in1_rlast_o;
  logic [1:0] f_in0_bresp_o, f_in0_rresp_o, f_in1_bresp_o, f_in1_rresp_o;
  logic [2:0] f_in0_bid_o, f_in0_rid_o, f_in1_bid_o, f_in1_rid_o;
  logic [31:0] f_in0_rdata_o, f_in1_rdata_o, f_out_addr_o, f_out_wdata_o;
  logic f_out_valid_o, f_out_write_o, f_out_bready_o, f_out_rready_o;
  logic [3:0] f_out_id_o, f_out_wstrb_o;
  logic [7:0] f_out_len_o;
  logic [1:0] f_out_burst_o;

  logic_capture_mem_arb #(.PRIO_RR(1'b1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .in0_valid_i(in0_valid_i), .in0_write_i(in0_write_i), .in0_addr_i(in0_addr_i), .in0_id_i(in0_id_i),
    .in0_len_i(in0_len_i), .in0_burst_i(in0_burst_i), .in0_wdata_i(in0_wdata_i), .in0_wstrb_i(in0_wstrb_i),
    .in0_accept_o(in0_accept_o), .in0_bvalid_o(in0_bvalid_o), .in0_bresp_o(in0_bresp_o), .in0_bid_o(in0_bid_o),
    .in0_bready_i(in0_bready_i), .in0_rvalid_o(in0_rvalid_o), .in0_rdata_o(in0_rdata_o), .in0_rresp_o(in0_rresp_o),
    .in0_rid_o(in0_rid_o), .in0_rlast_o(in0_rlast_o), .in0_rready_i(in0_rready_i),
    .in1_valid_i(in1_valid_i), .in1_write_i(in1_write_i), .in1_addr_i(in1_addr_i), .in1_id_i(in1_id_i),
    .in1_len_i(in1_len_i), .in1_burst_i(in1_burst_i), .in1_wdata_i(in1_wdata_i), .in1_wstrb_i(in1_wstrb_i),
    .in1_accept_o(in1_accept_o), .in1_bvalid_o(in1_bvalid_o), .in1_bresp_o(in1_bresp_o), .in1_bid_o(in1_bid_o),
    .in1_bready_i(in1_bready_i), .in1_rvalid_o(in1_rvalid_o), .in1_rdata_o(in1_rdata_o), .in1_rresp_o(in1_rresp_o),
    .in1_rid_o(in1_rid_o), .in1_rlast_o(in1_rlast_o), .in1_rready_i(in1_rready_i),
    .out_valid_o(out_valid_o), .out_write_o(out_write_o), .out_addr_o(out_addr_o), .out_id_o(out_id_o),
    .out_len_o(out_len_o), .out_burst_o(out_burst_o), .out_wdata_o(out_wdata_o), .out_wstrb_o(out_wstrb_o),
    .out_accept_i(out_accept_i), .out_bvalid_i(out_bvalid_i), .out_bresp_i(out_bresp_i), .out_bid_i(out_bid_i),
    .out_bready_o(out_bready_o), .out_rvalid_i(out_rvalid_i), .out_rdata_i(out_rdata_i), .out_rresp_i(out_rresp_i),
    .out_rid_i(out_rid_i), .out_rlast_i(out_rlast_i), .out_rready_o(out_rready_o)
  );

  logic_capture_mem_arb #(.PRIO_RR(1'b0)) dut_fixed (
    .clk_i(clk_i), .rst_ni(f_rst_n),
    .in0_valid_i(in0_valid_i), .in0_write_i(in0_write_i), .in0_addr_i(in0_addr_i), .in0_id_i(in0_id_i),
    .in0_len_i(in0_len_i), .in0_burst_i(in0_burst_i), .in0_wdata_i(in0_wdata_i), .in0_wstrb_i(in0_wstrb_i),
    .in0_accept_o(f_in0_accept_o), .in0_bvalid_o(f_in0_bvalid_o), .in0_bresp_o(f_in0_bresp_o), .in0_bid_o(f_in0_bid_o),
    .in0_bready_i(in0_bready_i), .in0_rvalid_o(f_in0_rvalid_o), .in0_rdata_o(f_in0_rdata_o), .in0_rresp_o(f_in0_rresp_o),
    .in0_rid_o(f_in0_rid_o), .in0_rlast_o(f_in0_rlast_o), .in0_rready_i(in0_rready_i),
    .in1_valid_i(in1_valid_i), .in1_write_i(in1_write_i), .in1_addr_i(in1_addr_i), .in1_id_i(in1_id_i),
    .in1_len_i(in1_len_i), .in1_burst_i(in1_burst_i), .in1_wdata_i(in1_wdata_i), .in1_wstrb_i(in1_wstrb_i),
    .in1_accept_o(f_in1_accept_o), .in1_bvalid_o(f_in1_bvalid_o), .in1_bresp_o(f_in1_bresp_o), .in1_bid_o(f_in1_bid_o),
    .in1_bready_i(in1_bready_i), .in1_rvalid_o(f_in1_rvalid_o), .in1_rdata_o(f_in1_rdata_o), .in1_rresp_o(f_in1_rresp_o),
    .in1_rid_o(f_in1_rid_o), .in1_rlast_o(f_in1_rlast_o), .in1_rready_i(in1_rready_i),
    .out_valid_o(f_out_valid_o), .out_write_o(f_out_write_o), .out_addr_o(f_out_addr_o), .out_id_o(f_out_id_o),
    .out_len_o(f_out_len_o), .out_burst_o(f_out_burst_o), .out_wdata_o(f_out_wdata_o), .out_wstrb_o(f_out_wstrb_o),
    .out_accept_i(out_accept_i), .out_bvalid_i(out_bvalid_i), .out_bresp_i(out_bresp_i), .out_bid_i(out_bid_i),
    .out_bready_o(f_out_bready_o), .out_rvalid_i(out_rvalid_i), .out_rdata_i(out_rdata_i), .out_rresp_i(out_rresp_i),
    .out_rid_i(out_rid_i), .out_rlast_i(out_rlast_i), .out_rready_o(f_out_rready_o)
  );

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [7:0]  len;
    logic [3:0]  strb;
  } exp_t;

  typedef struct {
    logic       valid;
    logic [3:0] tag;
    logic       rdy0;
    logic       rdy1;
    logic       e_v0;
    logic       e_v1;
    logic       e_rdy;
  } vec_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  logic chk_fixed = 1'b0;

  // Requester models: one outstanding burst each, optionally repeated.
  int          beats[2], txns[2], bidx[2];
  logic        gate[2], wr[2];
  logic [31:0] addr[2];
  logic [2:0]  rid[2];
  logic [7:0]  len[2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive();
    in0_valid_i = (beats[0] > 0) && !gate[0];
    in0_write_i = wr[0];  in0_addr_i = addr[0]; in0_id_i = rid[0]; in0_len_i = len[0];
    in0_burst_i = 2'b01;  in0_wdata_i = addr[0] ^ 32'(bidx[0]); in0_wstrb_i = 4'hF;
    in1_valid_i = (beats[1] > 0) && !gate[1];
    in1_write_i = wr[1];  in1_addr_i = addr[1]; in1_id_i = rid[1]; in1_len_i = len[1];
    in1_burst_i = 2'b01;  in1_wdata_i = addr[1] ^ 32'(bidx[1]); in1_wstrb_i = 4'h3;
  endtask

  task automatic start(input int r, input logic [31:0] a, input logic [2:0] id,
                       input logic w, input logic [7:0] l, input int ntx);
    addr[r] = a; rid[r] = id; wr[r] = w; len[r] = l;
    beats[r] = w ? int'(l) + 1 : 1;
    txns[r] = ntx - 1; bidx[r] = 0; gate[r] = 1'b0;
  endtask

  task automatic push(input int r, input int nb);
    exp_t e;
    for (int b = 0; b < nb; b++) begin
      e.id = {r[0], rid[r]}; e.addr = addr[r]; e.wr = wr[r];
      e.wdata = addr[r] ^ 32'(b); e.len = len[r]; e.strb = (r == 0) ? 4'hF : 4'h3;
      sb_q.push_back(e);
    end
  endtask

  // One clock: score any handshake at the negedge, then advance requesters.
  task automatic cyc();
    logic acc[2];
    exp_t e;
    @(negedge clk_i);
    if (out_valid_o && out_accept_i) begin
      check("sb_pending", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("sb_id", 64'(out_id_o), 64'(e.id));
        check("sb_addr", 64'(out_addr_o), 64'(e.addr));
        check("sb_write", 64'(out_write_o), 64'(e.wr));
        check("sb_wdata", 64'(out_wdata_o), 64'(e.wdata));
        check("sb_len", 64'(out_len_o), 64'(e.len));
        check("sb_wstrb", 64'(out_wstrb_o), 64'(e.strb));
      end
    end
    if (chk_fixed && in0_valid_i && in1_valid_i) begin
      check("fixed_grant", 64'(f_out_id_o[3]), 64'd0);
      check("fixed_acc1", 64'(f_in1_accept_o), 64'd0);
    end
    acc[0] = in0_accept_o;
    acc[1] = in1_accept_o;
    @(posedge clk_i);
    #1;
    for (int r = 0; r < 2; r++) begin
      if (acc[r]) begin
        bidx[r]++;
        beats[r]--;
        if (beats[r] == 0 && txns[r] > 0) begin
          txns[r]--;
          beats[r] = wr[r] ? int'(len[r]) + 1 : 1;
          bidx[r] = 0;
        end
      end
    end
    drive();
    #1;
  endtask

  vec_t tbl[6];

  initial begin
    tbl[0] = '{1'b1, 4'h3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 4'hB, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 4'hB, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[3] = '{1'b0, 4'h5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 4'hC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    for (int r = 0; r < 2; r++) begin
      beats[r] = 0; txns[r] = 0; bidx[r] = 0; gate[r] = 1'b0; wr[r] = 1'b0;
      addr[r] = '0; rid[r] = '0; len[r] = '0;
    end
    drive();
    rst_ni = 1'b0; f_rst_n = 1'b0; out_accept_i = 1'b1;
    out_bvalid_i = 1'b0; out_bresp_i = 2'd0; out_bid_i = 4'd0; in0_bready_i = 1'b0; in1_bready_i = 1'b0;
    out_rvalid_i = 1'b0; out_rdata_i = '0; out_rresp_i = 2'd0; out_rid_i = 4'd0; out_rlast_i = 1'b0;
    in0_rready_i = 1'b0; in1_rready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_out_valid", 64'(out_valid_o), 64'd0);
    check("rst_acc0", 64'(in0_accept_o), 64'd0);
    check("rst_acc1", 64'(in1_accept_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1; f_rst_n = 1'b1;
    @(posedge clk_i);
    #1;

    // Response steering table, applied to B then R.
    for (int i = 0; i < 6; i++) begin
      out_bvalid_i = tbl[i].valid; out_bid_i = tbl[i].tag; out_bresp_i = 2'(i);
      in0_bready_i = tbl[i].rdy0; in1_bready_i = tbl[i].rdy1;
      #1;
      check("b_v0", 64'(in0_bvalid_o), 64'(tbl[i].e_v0));
      check("b_v1", 64'(in1_bvalid_o), 64'(tbl[i].e_v1));
      check("b_ready", 64'(out_bready_o), 64'(tbl[i].e_rdy));
      check("b_bid", 64'({in1_bid_o, in0_bresp_o}), 64'({tbl[i].tag[2:0], 2'(i)}));
    end
    for (int i = 0; i < 6; i++) begin
      out_rvalid_i = tbl[i].valid; out_rid_i = tbl[i].tag; out_rdata_i = 32'hD000_0000 + 32'(i);
      out_rlast_i = tbl[i].tag[0]; in0_rready_i = tbl[i].rdy0; in1_rready_i = tbl[i].rdy1;
      #1;
      check("r_v0", 64'(in0_rvalid_o), 64'(tbl[i].e_v0));
      check("r_v1", 64'(in1_rvalid_o), 64'(tbl[i].e_v1));
      check("r_ready", 64'(out_rready_o), 64'(tbl[i].e_rdy));
      check("r_fields", 64'({in0_rid_o, in1_rdata_o, in1_rlast_o}),
            64'({tbl[i].tag[2:0], 32'hD000_0000 + 32'(i), tbl[i].tag[0]}));
    end
    out_bvalid_i = 1'b0; out_rvalid_i = 1'b0;

    // Single read from requester 1, then its response.
    start(1, 32'h100, 3'd2, 1'b0, 8'd0, 1); push(1, 1); drive(); #1;
    check("t1_out_id", 64'(out_id_o), 64'hA);
    check("t1_acc1", 64'(in1_accept_o), 64'd1);
    check("t1_acc0", 64'(in0_accept_o), 64'd0);
    cyc();
    check("t1_idle", 64'(out_valid_o), 64'd0);
    out_rvalid_i = 1'b1; out_rid_i = 4'hA; in1_rready_i = 1'b1; in0_rready_i = 1'b0; #1;
    check("t1_r1", 64'({in1_rvalid_o, in1_rid_o, in0_rvalid_o, out_rready_o}), 64'({1'b1, 3'd2, 1'b0, 1'b1}));
    out_rvalid_i = 1'b0;

    // Write burst len 3 from 0 against a read from 1.
    start(0, 32'h200, 3'd1, 1'b1, 8'd3, 1); start(1, 32'h300, 3'd5, 1'b0, 8'd0, 1);
    push(0, 4); push(1, 1); drive(); #1;
    for (int i = 0; i < 4; i++) begin
      check("t2_no_acc1", 64'(in1_accept_o), 64'd0);
      cyc();
    end
    check("t2_read_next", 64'(in1_accept_o), 64'd1);
    cyc();
    check("t2_sb_empty", 64'(sb_q.size()), 64'd0);

    // Burst with a 5-cycle gap after beat 2.
    start(0, 32'h400, 3'd3, 1'b1, 8'd3, 1); start(1, 32'h500, 3'd6, 1'b0, 8'd0, 1);
    push(0, 4); push(1, 1); drive(); #1;
    cyc(); cyc();
    gate[0] = 1'b1; drive(); #1;
    for (int i = 0; i < 5; i++) begin
      check("t3_gap_valid", 64'(out_valid_o), 64'd0);
      check("t3_gap_acc1", 64'(in1_accept_o), 64'd0);
      check("t3_gap_owner", 64'(out_id_o[3]), 64'd0);
      cyc();
    end
    gate[0] = 1'b0; drive(); #1;
    repeat (3) cyc();
    check("t3_sb_empty", 64'(sb_q.size()), 64'd0);

    // Round robin on continuous reads; the fixed-priority copy always picks 0.
    f_rst_n = 1'b0; #1; f_rst_n = 1'b1;
    start(0, 32'h600, 3'd0, 1'b0, 8'd0, 4); start(1, 32'h700, 3'd1, 1'b0, 8'd0, 3);
    for (int i = 0; i < 7; i++) push(i % 2, 1);
    drive(); #1;
    chk_fixed = 1'b1;
    repeat (7) cyc();
    chk_fixed = 1'b0;
    check("t4_sb_empty", 64'(sb_q.size()), 64'd0);

    // Hold: requester 1 (currently favoured) arrives while 0 waits for accept.
    out_accept_i = 1'b0;
    start(0, 32'h800, 3'd4, 1'b0, 8'd0, 1); push(0, 1); drive(); #1;
    check("t5_c1_id", 64'(out_id_o), 64'h4);
    cyc();
    start(1, 32'h900, 3'd7, 1'b0, 8'd0, 1); push(1, 1); drive(); #1;
    for (int i = 0; i < 2; i++) begin
      check("t5_hold_id", 64'(out_id_o), 64'h4);
      check("t5_hold_addr", 64'(out_addr_o), 64'h800);
      check("t5_hold_acc1", 64'(in1_accept_o), 64'd0);
      cyc();
    end
    out_accept_i = 1'b1; #1;
    check("t5_acc0", 64'(in0_accept_o), 64'd1);
    cyc(); cyc();
    check("t5_sb_empty", 64'(sb_q.size()), 64'd0);

    // Asynchronous reset inside a len-7 burst.
    start(0, 32'hA00, 3'd0, 1'b1, 8'd7, 1); start(1, 32'hB00, 3'd1, 1'b0, 8'd0, 1);
    push(0, 1); drive(); #1;
    cyc();
    gate[0] = 1'b1; drive(); #1;
    check("t6_lock_valid", 64'(out_valid_o), 64'd0);
    check("t6_lock_acc1", 64'(in1_accept_o), 64'd0);
    out_accept_i = 1'b0; #1;
    rst_ni = 1'b0; #1;
    check("t6_rst_valid", 64'(out_valid_o), 64'd1);
    check("t6_rst_id", 64'(out_id_o), 64'h9);
    check("t6_rst_cnt", 64'(dut.r_beat_cnt), 64'd0);
    for (int r = 0; r < 2; r++) begin beats[r] = 0; gate[r] = 1'b0; end
    drive();
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    check("t6_sb_empty", 64'(sb_q.size()), 64'd0);
    check("t6_idle", 64'(out_valid_o), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire
